// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator.
// Provides the 640x480@60 and 320x240 half-rate mode presets, the sync
// polarity constants and a counter width helper.
package vga_timing_pkg;

  // Sync polarity: the level that the sync output drives while it is active.
  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // 640x480@60, 25.175 MHz pixel clock, 800x525 total raster.
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam int VGA640_CLK_DIV  = 1;

  // 320x240 at half pixel rate, 400x262 total raster.
  localparam int QVGA_H_ACTIVE = 320;
  localparam int QVGA_H_FP     = 8;
  localparam int QVGA_H_SYNC   = 48;
  localparam int QVGA_H_BP     = 24;
  localparam int QVGA_V_ACTIVE = 240;
  localparam int QVGA_V_FP     = 5;
  localparam int QVGA_V_SYNC   = 1;
  localparam int QVGA_V_BP     = 16;
  localparam int QVGA_CLK_DIV  = 2;

  // Bits needed to hold 0..total-1; never narrower than one bit.
  function automatic int cnt_width(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap, blank and sync decode.
// Blank and sync are registered from the value the counter is about to
// take, so they always line up with the registered count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE = 640,
  parameter int   FP     = 16,
  parameter int   SYNC   = 96,
  parameter int   BP     = 48,
  parameter logic POL    = SYNC_ACTIVE_LOW,
  localparam int  TOTAL  = ACTIVE + FP + SYNC + BP,
  localparam int  W      = cnt_width(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt,
  output logic         wrap,
  output logic         blank,
  output logic         blank_nxt,
  output logic         sync
);

  // One extra bit so the sync end bound can equal TOTAL when BP is zero.
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W:0]   ACT_E      = (W+1)'(ACTIVE);
  localparam logic [W:0]   SYNC_BEG_E = (W+1)'(ACTIVE + FP);
  localparam logic [W:0]   SYNC_END_E = (W+1)'(ACTIVE + FP + SYNC);

  logic sync_nxt;

  // Next count, wrap strobe and decode of the next count.
  always_comb begin
    wrap      = inc && (cnt == LAST);
    cnt_nxt   = cnt;
    if (inc) begin
      cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
    end
    blank_nxt = ({1'b0, cnt_nxt} >= ACT_E);
    sync_nxt  = ({1'b0, cnt_nxt} >= SYNC_BEG_E) && ({1'b0, cnt_nxt} < SYNC_END_E);
  end

  // Count and decoded outputs advance together, only on an increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      blank <= 1'b0;
      sync  <= ~POL;
    end else if (inc) begin
      cnt   <= cnt_nxt;
      blank <= blank_nxt;
      sync  <= sync_nxt ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel clock divider, horizontal and vertical
// counters, sync/blank decode, pixel coordinates and line/frame pulses.
// Optional feature: define VGA_LINE_IRQ_EN to enable the line compare pulse
// on line_irq; otherwise line_cmp is ignored and line_irq is tied low.
// All outputs are registered and change only on a pixel tick, decoded from
// the counter value being loaded, so every output matches x/y with no lag.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE  = VGA640_H_ACTIVE,
  parameter int   H_FP      = VGA640_H_FP,
  parameter int   H_SYNC    = VGA640_H_SYNC,
  parameter int   H_BP      = VGA640_H_BP,
  parameter int   V_ACTIVE  = VGA640_V_ACTIVE,
  parameter int   V_FP      = VGA640_V_FP,
  parameter int   V_SYNC    = VGA640_V_SYNC,
  parameter int   V_BP      = VGA640_V_BP,
  parameter logic HSYNC_POL = SYNC_ACTIVE_LOW,
  parameter logic VSYNC_POL = SYNC_ACTIVE_LOW,
  parameter int   CLK_DIV   = VGA640_CLK_DIV,
  localparam int  H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HW        = cnt_width(H_TOTAL),
  localparam int  VW        = cnt_width(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          active,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  input  logic [VW-1:0] line_cmp,
  output logic          line_irq
);

  localparam int            DW       = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          h_wrap;
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic          h_blank_nxt;
  logic          v_blank_nxt;
  logic          v_wrap_unused;
  logic          h_zero_nxt;
  logic          v_zero_nxt;

  assign tick       = en && (div_cnt == DIV_LAST);
  assign h_zero_nxt = (h_nxt == '0);
  assign v_zero_nxt = (v_nxt == '0);

  // Pixel clock divider: one tick every CLK_DIV enabled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HSYNC_POL)
  ) u_h_axis (
    .clk       (clk),
    .rst       (rst),
    .inc       (tick),
    .cnt       (x),
    .cnt_nxt   (h_nxt),
    .wrap      (h_wrap),
    .blank     (hblank),
    .blank_nxt (h_blank_nxt),
    .sync      (hsync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VSYNC_POL)
  ) u_v_axis (
    .clk       (clk),
    .rst       (rst),
    .inc       (h_wrap),
    .cnt       (y),
    .cnt_nxt   (v_nxt),
    .wrap      (v_wrap_unused),
    .blank     (vblank),
    .blank_nxt (v_blank_nxt),
    .sync      (vsync)
  );

  // Active and line/frame pulses; reset value suppresses the pulses so the
  // first frame_start appears on the first wrap back to (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (tick) begin
      active      <= ~h_blank_nxt & ~v_blank_nxt;
      line_start  <= h_zero_nxt;
      frame_start <= h_zero_nxt & v_zero_nxt;
    end
  end

`ifdef VGA_LINE_IRQ_EN
  // Line compare pulse: line_cmp is sampled on the tick that enters column 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_irq <= 1'b0;
    end else if (tick) begin
      line_irq <= h_zero_nxt && (v_nxt == line_cmp);
    end
  end
`else
  logic unused_line_cmp;
  assign unused_line_cmp = ^line_cmp;
  assign line_irq        = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in the small mode (8x6 raster), one instance at
// CLK_DIV=1 and one at CLK_DIV=3 sharing clock, reset, enable and line_cmp.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
`ifdef VGA_LINE_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] line_cmp;
  always #5 clk = ~clk;

  logic       h1, v1, hb1, vb1, a1, ls1, fs1, li1;
  logic [2:0] x1, y1;
  logic       h3, v3, hb3, vb3, a3, ls3, fs3, li3;
  logic [2:0] x3, y3;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(1)
  ) dut1 (
    .clk(clk), .rst(rst), .en(en), .hsync(h1), .vsync(v1), .hblank(hb1),
    .vblank(vb1), .active(a1), .x(x1), .y(y1), .line_start(ls1),
    .frame_start(fs1), .line_cmp(line_cmp), .line_irq(li1)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(3)
  ) dut3 (
    .clk(clk), .rst(rst), .en(en), .hsync(h3), .vsync(v3), .hblank(hb3),
    .vblank(vb3), .active(a3), .x(x3), .y(y3), .line_start(ls3),
    .frame_start(fs3), .line_cmp(line_cmp), .line_irq(li3)
  );

  logic [13:0] dv1, dv3;
  assign dv1 = {h1, v1, hb1, vb1, a1, ls1, fs1, li1, x1, y1};
  assign dv3 = {h3, v3, hb3, vb3, a3, ls3, fs3, li3, x3, y3};

  // ---------------- counters / check ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pixel index since reset = enabled cycles / CLK_DIV; raster position is
  // that index modulo the frame size.
  int   ec = 0;
  logic irq_m1 = 1'b0;
  logic irq_m3 = 1'b0;
  logic cmp_on = 1'b0;

  function automatic logic model_irq(input int t, input logic [2:0] lc);
    int p;
    p = t % FT;
    model_irq = ((p % HT) == 0) && ((p / HT) == int'(lc));
    if (!IRQ_ON) model_irq = 1'b0;
  endfunction

  function automatic logic [13:0] exp_vec(input int t, input logic irq);
    int p, px, py;
    logic hs, vs, hbk, vbk, act, ls, fs;
    p   = t % FT;
    px  = p % HT;
    py  = p / HT;
    hs  = !(px >= HA + HF && px < HA + HF + HS);
    vs  = !(py >= VA + VF && py < VA + VF + VS);
    hbk = (px >= HA);
    vbk = (py >= VA);
    act = !hbk && !vbk;
    ls  = (px == 0) && (t > 0);
    fs  = ls && (py == 0);
    return {hs, vs, hbk, vbk, act, ls, fs, irq, 3'(px), 3'(py)};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ec     = 0;
      irq_m1 = 1'b0;
      irq_m3 = 1'b0;
    end else if (en) begin
      ec     = ec + 1;
      irq_m1 = model_irq(ec, line_cmp);
      if (ec % 3 == 0) irq_m3 = model_irq(ec / 3, line_cmp);
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cycle_d1", 32'(dv1), 32'(exp_vec(ec, irq_m1)));
      chk("cycle_d3", 32'(dv3), 32'(exp_vec(ec / 3, irq_m3)));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_rise(input int sel, input int bound, output int waited);
    logic prev, cur, found;
    prev   = (sel == 0) ? fs1 : fs3;
    found  = 1'b0;
    waited = bound;
    for (int i = 1; i <= bound && !found; i++) begin
      @(negedge clk);
      cur = (sel == 0) ? fs1 : fs3;
      if (cur && !prev) begin
        waited = i;
        found  = 1'b1;
      end
      prev = cur;
    end
    if (!found) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_frame_start: no rising edge within %0d clks", bound);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int w;
    int c1, c3;
    rst      = 1'b1;
    en       = 1'b0;
    line_cmp = 3'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_on = 1'b1;
    chk("reset_d1", 32'(dv1), 32'({8'b1100_1000, 3'd0, 3'd0}));
    chk("reset_d3", 32'(dv3), 32'({8'b1100_1000, 3'd0, 3'd0}));

    @(posedge clk);
    #1 rst = 1'b0;
    en = 1'b1;

    // Horizontal sweep
    clocks(4);
    chk("x_at4", 32'(x1), 32'd4);
    chk("hblank_at4", 32'(hb1), 32'd1);
    chk("hsync_at4", 32'(h1), 32'd1);
    clocks(1);
    chk("x_at5", 32'(x1), 32'd5);
    chk("hsync_at5", 32'(h1), 32'd0);
    clocks(2);
    chk("hsync_at7", 32'(h1), 32'd1);
    clocks(1);
    chk("wrap_x", 32'(x1), 32'd0);
    chk("wrap_y", 32'(y1), 32'd1);
    chk("line_start_wrap", 32'(ls1), 32'd1);
    chk("frame_start_line1", 32'(fs1), 32'd0);
    chk("div3_x_at8", 32'(x3), 32'd2);

    // Frame period at CLK_DIV=1
    wait_rise(0, 200, w);
    chk("first_fs_d1_wait", 32'(w), 32'd40);
    chk("first_fs_d1_xy", 32'({x1, y1}), 32'd0);
    wait_rise(0, 200, w);
    chk("frame_period_d1", 32'(w), 32'd48);

    // Frame period and pixel stretch at CLK_DIV=3
    wait_rise(1, 200, w);
    chk("first_fs_d3_xy", 32'({x3, y3}), 32'd0);
    chk("ls_d3_clk0", 32'(ls3), 32'd1);
    clocks(2);
    chk("ls_d3_clk2", 32'(ls3), 32'd1);
    clocks(1);
    chk("ls_d3_clk3", 32'(ls3), 32'd0);
    chk("x_d3_clk3", 32'(x3), 32'd1);
    wait_rise(1, 300, w);
    chk("frame_period_d3", 32'(w + 3), 32'd144);

    // Freeze with en low at (2,1)
    clocks(10);
    chk("pre_freeze_xy", 32'({x1, y1}), 32'({3'd2, 3'd1}));
    en = 1'b0;
    clocks(10);
    chk("freeze_d1", 32'(dv1), 32'({8'b1100_1000, 3'd2, 3'd1}));
    chk("freeze_d3_xy", 32'({x3, y3}), 32'({3'd3, 3'd0}));
    en = 1'b1;
    clocks(1);
    chk("resume_xy", 32'({x1, y1}), 32'({3'd3, 3'd1}));

    // Asynchronous reset mid-line at (6,2)
    clocks(11);
    chk("pre_rst_hsync", 32'(h1), 32'd0);
    chk("pre_rst_active", 32'(a1), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_d1", 32'(dv1), 32'({8'b1100_1000, 3'd0, 3'd0}));
    chk("async_rst_d3", 32'(dv3), 32'({8'b1100_1000, 3'd0, 3'd0}));
    @(posedge clk);
    #1 rst = 1'b0;

    // Line compare: line_cmp=2 fires once per frame at (0,2)
    c1 = 0;
    c3 = 0;
    for (int i = 1; i <= 48; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (li1) c1++;
      if (li3) c3++;
      if (i == 16) chk("irq_at_0_2", 32'(li1), 32'(IRQ_ON));
    end
    chk("irq_count_cmp2_d1", 32'(c1), 32'(IRQ_ON));
    chk("irq_count_cmp2_d3", 32'(c3), 32'(IRQ_ON));

    // line_cmp beyond the raster never fires
    line_cmp = 3'd7;
    c1 = 0;
    c3 = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (li1) c1++;
      if (li3) c3++;
    end
    chk("irq_count_cmp7_d1", 32'(c1), 32'd0);
    chk("irq_count_cmp7_d3", 32'(c3), 32'd0);

    // ---------------- report ----------------
    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
